// File: rtl/axi_lite_pkg.sv
// Shared types and constants for the AXI-Lite master controller.
// Holds the controller FSM state type, AXI response codes, fixed
// data/strobe widths and the packed user-response payload.
package axi_lite_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned RESP_W = 2;

    localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] RESP_EXOKAY = 2'b01;
    localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
    localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_DATA = 3'd4,
        RSP     = 3'd5
    } state_e;

    // Response returned to the user side
    typedef struct packed {
        logic              write;
        logic [RESP_W-1:0] resp;
        logic [DATA_W-1:0] rdata;
    } rsp_t;

    // States in which the controller is waiting on the AXI slave
    function automatic logic is_wait_state(input state_e s);
        return (s == WR_REQ) || (s == WR_RESP) || (s == RD_REQ) || (s == RD_DATA);
    endfunction

endpackage

// File: rtl/axi_wait_timer.sv
// Per-state wait counter for the AXI-Lite master.
// Ports:
//   clk_i, rst_ni    clock, async active-low reset
//   clr_i            clear to zero (state entry), dominates en_i
//   en_i             count one waited cycle
//   expired_o        registered: count has reached TIMEOUT
//   expire_next_c    combinational: count will be TIMEOUT next cycle
// The count saturates at TIMEOUT, so it never wraps.
module axi_wait_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o,
    output logic expire_next_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             expired_q;

    // Next count: clear on entry, else saturating increment
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CNT_W'(TIMEOUT))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign expire_next_c = (cnt_d == CNT_W'(TIMEOUT));
    assign expired_o     = expired_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            expired_q <= expire_next_c;
        end
    end

endmodule

// File: rtl/axi_lite_master_ctrl.sv
// Single-outstanding AXI-Lite master: turns one user command into an
// AXI-Lite read or write and returns the response on a user handshake.
// Ports:
//   clk_i, rst_ni                         clock, async active-low reset
//   cmd_valid_i/cmd_ready_o, cmd_write_i, cmd_addr_i, cmd_wdata_i,
//   cmd_wstrb_i                           user command
//   rsp_valid_o/rsp_ready_i, rsp_rdata_o, rsp_resp_o, rsp_write_o
//                                         user response
//   axi_aw*, axi_w*, axi_b*, axi_ar*, axi_r*  AXI-Lite master channels
// Every output is a flop. A channel stuck longer than TIMEOUT cycles is
// aborted and reported as SLVERR.
module axi_lite_master_ctrl
    import axi_lite_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    // user command
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_write_i,
    input  logic [ADDR_W-1:0]   cmd_addr_i,
    input  logic [DATA_W-1:0]   cmd_wdata_i,
    input  logic [STRB_W-1:0]   cmd_wstrb_i,
    // user response
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [DATA_W-1:0]   rsp_rdata_o,
    output logic [RESP_W-1:0]   rsp_resp_o,
    output logic                rsp_write_o,
    // write address
    output logic                axi_awvalid_o,
    output logic [ADDR_W-1:0]   axi_awaddr_o,
    input  logic                axi_awready_i,
    // write data
    output logic                axi_wvalid_o,
    output logic [DATA_W-1:0]   axi_wdata_o,
    output logic [STRB_W-1:0]   axi_wstrb_o,
    input  logic                axi_wready_i,
    // write response
    input  logic                axi_bvalid_i,
    input  logic [RESP_W-1:0]   axi_bresp_i,
    output logic                axi_bready_o,
    // read address
    output logic                axi_arvalid_o,
    output logic [ADDR_W-1:0]   axi_araddr_o,
    input  logic                axi_arready_i,
    // read data
    input  logic                axi_rvalid_i,
    input  logic [DATA_W-1:0]   axi_rdata_i,
    input  logic [RESP_W-1:0]   axi_rresp_i,
    output logic                axi_rready_o
);

    state_e state_q, state_d;

    logic              aw_done_q, aw_done_d;
    logic              w_done_q,  w_done_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [DATA_W-1:0] wdata_q,   wdata_d;
    logic [STRB_W-1:0] wstrb_q,   wstrb_d;
    rsp_t              rsp_q,     rsp_d;

    logic cmd_ready_q, cmd_ready_d;
    logic awvalid_q,   awvalid_d;
    logic wvalid_q,    wvalid_d;
    logic bready_q,    bready_d;
    logic arvalid_q,   arvalid_d;
    logic rready_q,    rready_d;
    logic rsp_valid_q, rsp_valid_d;

    logic timer_clr;
    logic timer_en;
    logic timer_expired;
    logic timer_expire_next;

    // Next-state and payload capture
    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rsp_d     = rsp_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid_i && cmd_ready_q) begin
                    state_d   = cmd_write_i ? WR_REQ : RD_REQ;
                    addr_d    = cmd_addr_i;
                    wdata_d   = cmd_wdata_i;
                    wstrb_d   = cmd_wstrb_i;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    rsp_d     = '{write: cmd_write_i, resp: RESP_OKAY, rdata: '0};
                end
            end
            WR_REQ: begin
                // AW and W complete independently, in any order
                aw_done_d = aw_done_q | (awvalid_q & axi_awready_i);
                w_done_d  = w_done_q  | (wvalid_q  & axi_wready_i);
                if (aw_done_d && w_done_d) begin
                    state_d = WR_RESP;
                end else if (timer_expired) begin
                    state_d    = RSP;
                    rsp_d.resp = RESP_SLVERR;
                end
            end
            WR_RESP: begin
                if (bready_q && axi_bvalid_i) begin
                    state_d    = RSP;
                    rsp_d.resp = axi_bresp_i;
                end else if (timer_expired) begin
                    state_d    = RSP;
                    rsp_d.resp = RESP_SLVERR;
                end
            end
            RD_REQ: begin
                if (arvalid_q && axi_arready_i) begin
                    state_d = RD_DATA;
                end else if (timer_expired) begin
                    state_d     = RSP;
                    rsp_d.resp  = RESP_SLVERR;
                    rsp_d.rdata = '0;
                end
            end
            RD_DATA: begin
                if (rready_q && axi_rvalid_i) begin
                    state_d     = RSP;
                    rsp_d.resp  = axi_rresp_i;
                    rsp_d.rdata = axi_rdata_i;
                end else if (timer_expired) begin
                    state_d     = RSP;
                    rsp_d.resp  = RESP_SLVERR;
                    rsp_d.rdata = '0;
                end
            end
            RSP: begin
                if (rsp_valid_q && rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign timer_clr = (state_d != state_q);
    assign timer_en  = is_wait_state(state_q);

    axi_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .clr_i         (timer_clr),
        .en_i          (timer_en),
        .expired_o     (timer_expired),
        .expire_next_c (timer_expire_next)
    );

    // Registered handshake outputs; AXI valids/readies drop in the cycle
    // the wait count reaches TIMEOUT, one cycle before the abort to RSP.
    always_comb begin
        cmd_ready_d = (state_d == IDLE);
        awvalid_d   = (state_d == WR_REQ)  && !aw_done_d && !timer_expire_next;
        wvalid_d    = (state_d == WR_REQ)  && !w_done_d  && !timer_expire_next;
        bready_d    = (state_d == WR_RESP) && !timer_expire_next;
        arvalid_d   = (state_d == RD_REQ)  && !timer_expire_next;
        rready_d    = (state_d == RD_DATA) && !timer_expire_next;
        rsp_valid_d = (state_d == RSP);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_q       <= '0;
            cmd_ready_q <= 1'b1;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rsp_q       <= rsp_d;
            cmd_ready_q <= cmd_ready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign cmd_ready_o   = cmd_ready_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_q.rdata;
    assign rsp_resp_o    = rsp_q.resp;
    assign rsp_write_o   = rsp_q.write;
    assign axi_awvalid_o = awvalid_q;
    assign axi_awaddr_o  = addr_q;
    assign axi_wvalid_o  = wvalid_q;
    assign axi_wdata_o   = wdata_q;
    assign axi_wstrb_o   = wstrb_q;
    assign axi_bready_o  = bready_q;
    assign axi_arvalid_o = arvalid_q;
    assign axi_araddr_o  = addr_q;
    assign axi_rready_o  = rready_q;

endmodule

// File: tb/tb_axi_lite_master_ctrl.sv
// Directed bench for axi_lite_master_ctrl (TIMEOUT = 8).
// Control outputs are compared as one vector:
//   {cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid}
module tb_axi_lite_master_ctrl;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned TIMEOUT = 8;

    localparam logic [6:0] C_IDLE  = 7'b1000000;
    localparam logic [6:0] C_AW_W  = 7'b0110000;
    localparam logic [6:0] C_AW    = 7'b0100000;
    localparam logic [6:0] C_BRDY  = 7'b0001000;
    localparam logic [6:0] C_AR    = 7'b0000100;
    localparam logic [6:0] C_RRDY  = 7'b0000010;
    localparam logic [6:0] C_RSP   = 7'b0000001;
    localparam logic [6:0] C_NONE  = 7'b0000000;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              cmd_valid_i, cmd_ready_o, cmd_write_i;
    logic [ADDR_W-1:0] cmd_addr_i;
    logic [31:0]       cmd_wdata_i;
    logic [3:0]        cmd_wstrb_i;
    logic              rsp_valid_o, rsp_ready_i, rsp_write_o;
    logic [31:0]       rsp_rdata_o;
    logic [1:0]        rsp_resp_o;
    logic              axi_awvalid_o, axi_awready_i;
    logic [ADDR_W-1:0] axi_awaddr_o;
    logic              axi_wvalid_o, axi_wready_i;
    logic [31:0]       axi_wdata_o;
    logic [3:0]        axi_wstrb_o;
    logic              axi_bvalid_i, axi_bready_o;
    logic [1:0]        axi_bresp_i;
    logic              axi_arvalid_o, axi_arready_i;
    logic [ADDR_W-1:0] axi_araddr_o;
    logic              axi_rvalid_i, axi_rready_o;
    logic [31:0]       axi_rdata_i;
    logic [1:0]        axi_rresp_i;

    logic [6:0]  ctl;
    logic [34:0] rsp;
    assign ctl = {cmd_ready_o, axi_awvalid_o, axi_wvalid_o, axi_bready_o,
                  axi_arvalid_o, axi_rready_o, rsp_valid_o};
    assign rsp = {rsp_write_o, rsp_resp_o, rsp_rdata_o};

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    axi_lite_master_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
        .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_wstrb_i(cmd_wstrb_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_resp_o(rsp_resp_o), .rsp_write_o(rsp_write_o),
        .axi_awvalid_o(axi_awvalid_o), .axi_awaddr_o(axi_awaddr_o), .axi_awready_i(axi_awready_i),
        .axi_wvalid_o(axi_wvalid_o), .axi_wdata_o(axi_wdata_o), .axi_wstrb_o(axi_wstrb_o),
        .axi_wready_i(axi_wready_i),
        .axi_bvalid_i(axi_bvalid_i), .axi_bresp_i(axi_bresp_i), .axi_bready_o(axi_bready_o),
        .axi_arvalid_o(axi_arvalid_o), .axi_araddr_o(axi_araddr_o), .axi_arready_i(axi_arready_i),
        .axi_rvalid_i(axi_rvalid_i), .axi_rdata_i(axi_rdata_i), .axi_rresp_i(axi_rresp_i),
        .axi_rready_o(axi_rready_o)
    );

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present one command for a single cycle; returns in accept+1
    task automatic drive_cmd(input logic wr, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] strb);
        cmd_valid_i = 1'b1;
        cmd_write_i = wr;
        cmd_addr_i  = addr;
        cmd_wdata_i = data;
        cmd_wstrb_i = strb;
        tick();
        cmd_valid_i = 1'b0;
        cmd_addr_i  = '0;
        cmd_wdata_i = '0;
        cmd_wstrb_i = '0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) tick();
        checks++;
        if (ctl !== C_IDLE) begin
            errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, C_IDLE);
        end
        checks++;
        if ({rsp, axi_awaddr_o, axi_wdata_o, axi_wstrb_o} !== 103'd0) begin
            errors++; $display("FAIL reset_payload: got %h expected 0",
                               {rsp, axi_awaddr_o, axi_wdata_o, axi_wstrb_o});
        end
        rst_ni = 1'b1;
        tick();
        checks++;
        if (ctl !== C_IDLE) begin
            errors++; $display("FAIL post_reset_ctl: got %b expected %b", ctl, C_IDLE);
        end
    endtask

    task automatic test_write_zero_wait();
        drive_cmd(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
        checks++;
        if (ctl !== C_AW_W) begin
            errors++; $display("FAIL wr0_aw_w: got %b expected %b", ctl, C_AW_W);
        end
        checks++;
        if ({axi_awaddr_o, axi_wdata_o, axi_wstrb_o} !== {32'h0000_0010, 32'hDEAD_BEEF, 4'hF}) begin
            errors++; $display("FAIL wr0_payload: got %h expected %h",
                {axi_awaddr_o, axi_wdata_o, axi_wstrb_o}, {32'h0000_0010, 32'hDEAD_BEEF, 4'hF});
        end
        axi_awready_i = 1'b1; axi_wready_i = 1'b1;
        tick();
        axi_awready_i = 1'b0; axi_wready_i = 1'b0;
        checks++;
        if (ctl !== C_BRDY) begin
            errors++; $display("FAIL wr0_bready: got %b expected %b", ctl, C_BRDY);
        end
        axi_bvalid_i = 1'b1; axi_bresp_i = 2'b00;
        tick();
        axi_bvalid_i = 1'b0;
        checks++;
        if (ctl !== C_RSP) begin
            errors++; $display("FAIL wr0_rsp_latency: got %b expected %b", ctl, C_RSP);
        end
        checks++;
        if (rsp !== {1'b1, 2'b00, 32'h0}) begin
            errors++; $display("FAIL wr0_rsp: got %h expected %h", rsp, {1'b1, 2'b00, 32'h0});
        end
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        checks++;
        if (ctl !== C_IDLE) begin
            errors++; $display("FAIL wr0_idle: got %b expected %b", ctl, C_IDLE);
        end
    endtask

    task automatic test_write_aw_delay();
        logic [6:0] exp_ctl;
        drive_cmd(1'b1, 32'h0000_0030, 32'h0102_0304, 4'h5);
        for (int i = 0; i < 4; i++) begin
            exp_ctl = (i == 0) ? C_AW_W : C_AW;
            checks++;
            if (ctl !== exp_ctl) begin
                errors++; $display("FAIL wraw_ctl[%0d]: got %b expected %b", i, ctl, exp_ctl);
            end
            checks++;
            if (axi_awaddr_o !== 32'h0000_0030) begin
                errors++; $display("FAIL wraw_addr[%0d]: got %h expected %h", i, axi_awaddr_o, 32'h30);
            end
            axi_wready_i  = (i == 0);
            axi_awready_i = (i == 3);
            tick();
        end
        axi_wready_i = 1'b0; axi_awready_i = 1'b0;
        checks++;
        if (ctl !== C_BRDY) begin
            errors++; $display("FAIL wraw_bready: got %b expected %b", ctl, C_BRDY);
        end
        axi_bvalid_i = 1'b1; axi_bresp_i = 2'b01;
        tick();
        axi_bvalid_i = 1'b0; axi_bresp_i = 2'b00;
        checks++;
        if ({ctl, rsp} !== {C_RSP, 1'b1, 2'b01, 32'h0}) begin
            errors++; $display("FAIL wraw_rsp: got %h expected %h", {ctl, rsp}, {C_RSP, 1'b1, 2'b01, 32'h0});
        end
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (ctl !== C_IDLE) begin
                errors++; $display("FAIL wraw_single[%0d]: got %b expected %b", i, ctl, C_IDLE);
            end
            tick();
        end
    endtask

    task automatic test_read_wait();
        drive_cmd(1'b0, 32'h0000_0020, 32'h0, 4'h0);
        checks++;
        if ({ctl, axi_araddr_o} !== {C_AR, 32'h0000_0020}) begin
            errors++; $display("FAIL rd_ar: got %h expected %h", {ctl, axi_araddr_o}, {C_AR, 32'h20});
        end
        axi_arready_i = 1'b1;
        tick();
        axi_arready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ctl !== C_RRDY) begin
                errors++; $display("FAIL rd_rready[%0d]: got %b expected %b", i, ctl, C_RRDY);
            end
            if (i == 2) begin
                axi_rvalid_i = 1'b1; axi_rdata_i = 32'h1234_5678; axi_rresp_i = 2'b00;
            end
            tick();
        end
        axi_rvalid_i = 1'b0; axi_rdata_i = '0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({ctl, rsp} !== {C_RSP, 1'b0, 2'b00, 32'h1234_5678}) begin
                errors++; $display("FAIL rd_rsp[%0d]: got %h expected %h", i, {ctl, rsp},
                                   {C_RSP, 1'b0, 2'b00, 32'h1234_5678});
            end
            tick();
        end
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
    endtask

    task automatic test_read_decerr();
        drive_cmd(1'b0, 32'h0002_0000, 32'h0, 4'h0);
        checks++;
        if ({ctl, axi_araddr_o} !== {C_AR, 32'h0002_0000}) begin
            errors++; $display("FAIL rdde_ar: got %h expected %h", {ctl, axi_araddr_o}, {C_AR, 32'h0002_0000});
        end
        axi_arready_i = 1'b1;
        tick();
        axi_arready_i = 1'b0;
        axi_rvalid_i = 1'b1; axi_rdata_i = 32'h0; axi_rresp_i = 2'b11;
        tick();
        axi_rvalid_i = 1'b0; axi_rresp_i = 2'b00;
        checks++;
        if ({ctl, rsp} !== {C_RSP, 1'b0, 2'b11, 32'h0}) begin
            errors++; $display("FAIL rdde_rsp: got %h expected %h", {ctl, rsp}, {C_RSP, 1'b0, 2'b11, 32'h0});
        end
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
    endtask

    task automatic test_timeout();
        int n;
        drive_cmd(1'b1, 32'h0000_0040, 32'h0000_0055, 4'h3);
        axi_awready_i = 1'b1; axi_wready_i = 1'b1;
        tick();
        axi_awready_i = 1'b0; axi_wready_i = 1'b0;
        // a read beat while waiting on B must be ignored
        axi_rvalid_i = 1'b1; axi_rdata_i = 32'hFFFF_FFFF; axi_rresp_i = 2'b00;
        n = 0;
        while (axi_bready_o === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        checks++;
        if (n !== 8) begin
            errors++; $display("FAIL to_bready_cycles: got %0d expected 8", n);
        end
        checks++;
        if (ctl !== C_NONE) begin
            errors++; $display("FAIL to_drop: got %b expected %b", ctl, C_NONE);
        end
        // B arriving after bready dropped is ignored
        axi_bvalid_i = 1'b1; axi_bresp_i = 2'b00;
        tick();
        axi_bvalid_i = 1'b0; axi_rvalid_i = 1'b0; axi_rdata_i = '0;
        checks++;
        if ({ctl, rsp} !== {C_RSP, 1'b1, 2'b10, 32'h0}) begin
            errors++; $display("FAIL to_rsp: got %h expected %h", {ctl, rsp}, {C_RSP, 1'b1, 2'b10, 32'h0});
        end
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        checks++;
        if (ctl !== C_IDLE) begin
            errors++; $display("FAIL to_idle: got %b expected %b", ctl, C_IDLE);
        end
        drive_cmd(1'b0, 32'h0000_0044, 32'h0, 4'h0);
        checks++;
        if (ctl !== C_AR) begin
            errors++; $display("FAIL to_next_accept: got %b expected %b", ctl, C_AR);
        end
        axi_arready_i = 1'b1;
        tick();
        axi_arready_i = 1'b0;
        axi_rvalid_i = 1'b1; axi_rdata_i = 32'hA5A5_5A5A; axi_rresp_i = 2'b00;
        tick();
        axi_rvalid_i = 1'b0; axi_rdata_i = '0;
        checks++;
        if ({ctl, rsp} !== {C_RSP, 1'b0, 2'b00, 32'hA5A5_5A5A}) begin
            errors++; $display("FAIL to_next_rsp: got %h expected %h", {ctl, rsp},
                               {C_RSP, 1'b0, 2'b00, 32'hA5A5_5A5A});
        end
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
    endtask

    task automatic test_reset_midflight();
        drive_cmd(1'b0, 32'h0000_0080, 32'h0, 4'h0);
        axi_arready_i = 1'b1;
        tick();
        axi_arready_i = 1'b0;
        axi_rvalid_i = 1'b1; axi_rdata_i = 32'h0BAD_F00D; axi_rresp_i = 2'b00;
        tick();
        axi_rvalid_i = 1'b0; axi_rdata_i = '0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({ctl, rsp} !== {C_RSP, 1'b0, 2'b00, 32'h0BAD_F00D}) begin
                errors++; $display("FAIL rst_hold[%0d]: got %h expected %h", i, {ctl, rsp},
                                   {C_RSP, 1'b0, 2'b00, 32'h0BAD_F00D});
            end
            tick();
        end
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        drive_cmd(1'b0, 32'h0000_0084, 32'h0, 4'h0);
        axi_arready_i = 1'b1;
        tick();
        axi_arready_i = 1'b0;
        checks++;
        if (ctl !== C_RRDY) begin
            errors++; $display("FAIL rst_pre: got %b expected %b", ctl, C_RRDY);
        end
        // asynchronous reset between clock edges
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if ({ctl, rsp, axi_araddr_o} !== {C_IDLE, 35'h0, 32'h0}) begin
            errors++; $display("FAIL rst_async: got %h expected %h", {ctl, rsp, axi_araddr_o},
                               {C_IDLE, 35'h0, 32'h0});
        end
        rst_ni = 1'b1;
        axi_rvalid_i = 1'b1; axi_rdata_i = 32'h7777_7777;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ctl !== C_IDLE) begin
                errors++; $display("FAIL rst_no_rsp[%0d]: got %b expected %b", i, ctl, C_IDLE);
            end
        end
        axi_rvalid_i = 1'b0; axi_rdata_i = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_ni        = 1'b0;
        cmd_valid_i   = 1'b0; cmd_write_i = 1'b0;
        cmd_addr_i    = '0;   cmd_wdata_i = '0; cmd_wstrb_i = '0;
        rsp_ready_i   = 1'b0;
        axi_awready_i = 1'b0; axi_wready_i = 1'b0;
        axi_bvalid_i  = 1'b0; axi_bresp_i = '0;
        axi_arready_i = 1'b0;
        axi_rvalid_i  = 1'b0; axi_rdata_i = '0; axi_rresp_i = '0;

        test_reset();
        test_write_zero_wait();
        test_write_aw_delay();
        test_read_wait();
        test_read_decerr();
        test_timeout();
        test_reset_midflight();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_lite_master_ctrl.md
AXI_LITE_MASTER_CTRL -- requirements
Module: axi_lite_master_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, AXI address width.
REQ-002 SHALL have parameter TIMEOUT, default 255, maximum cycles waited in any one channel state before abort; TIMEOUT >= 1.
REQ-003 clk_i  in  1  single clock, all logic on rising edge.
REQ-004 rst_ni  in  1  asynchronous, active-low reset.
REQ-005 cmd_valid_i / cmd_ready_o  in/out  1  user command handshake.
REQ-006 cmd_write_i  in  1  1 = write, 0 = read.
REQ-007 cmd_addr_i  in  ADDR_W  target address; cmd_wdata_i  in  32  write data; cmd_wstrb_i  in  4  byte strobes.
REQ-008 rsp_valid_o / rsp_ready_i  out/in  1  user response handshake.
REQ-009 rsp_rdata_o  out  32  read data (0 for writes); rsp_resp_o  out  2  AXI response code; rsp_write_o  out  1  echo of command type.
REQ-010 axi_awvalid_o, axi_awaddr_o[ADDR_W], axi_awready_i  write-address channel.
REQ-011 axi_wvalid_o, axi_wdata_o[32], axi_wstrb_o[4], axi_wready_i  write-data channel.
REQ-012 axi_bvalid_i, axi_bresp_i[2], axi_bready_o  write-response channel.
REQ-013 axi_arvalid_o, axi_araddr_o[ADDR_W], axi_arready_i  read-address channel.
REQ-014 axi_rvalid_i, axi_rdata_i[32], axi_rresp_i[2], axi_rready_o  read-data channel.

Function
REQ-015 FSM states SHALL be IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP; one transaction outstanding at a time.
REQ-016 cmd_ready_o SHALL be 1 only in IDLE; command accepted on cmd_valid_i && cmd_ready_o, with addr/data/strb/type registered that cycle.
REQ-017 IDLE -> WR_REQ (write) or RD_REQ (read) on accept; awvalid+wvalid (or arvalid) SHALL assert the next cycle, all driven from registers.
REQ-018 In WR_REQ, AW and W SHALL be tracked by separate done flags; each valid drops the cycle after its own handshake; either order or same cycle allowed; exit to WR_RESP when both done.
REQ-019 Once asserted, a valid SHALL stay high with stable payload until handshake (no retraction) unless timeout abort.
REQ-020 axi_bready_o SHALL be 1 only in WR_RESP; on bvalid capture bresp, go RSP.
REQ-021 RD_REQ: arvalid until arready, then RD_DATA; axi_rready_o 1 only in RD_DATA; on rvalid capture rdata/rresp, go RSP.
REQ-022 RSP: rsp_valid_o = 1 with stable payload until rsp_ready_i; then IDLE; earliest next accept one cycle later.
REQ-023 Minimum latency with zero-wait slave: accept cycle N, AXI valid at N+1, B/R handshake N+2, rsp_valid_o at N+3.
REQ-024 A wait counter SHALL clear on every state entry and increment in WR_REQ, WR_RESP, RD_REQ, RD_DATA; at count == TIMEOUT, drop all AXI valids/readies, go RSP with resp 2'b10 (SLVERR), rdata 0.
REQ-025 Responses arriving outside their enabling state (bvalid outside WR_RESP, rvalid outside RD_DATA) SHALL be ignored.
REQ-026 Wait counter width SHALL be clog2(TIMEOUT+1); no wrap below TIMEOUT.

Reset
REQ-027 On rst_ni low, asynchronously: state IDLE, all AXI valid/ready outputs 0, rsp_valid_o 0, cmd_ready_o 1 after deassertion, payload registers 0, counter 0.
REQ-028 Reset mid-transaction SHALL abandon it with no response generated.

Structure
REQ-029 A shared package axi_lite_pkg SHALL hold the FSM state type and response constants OKAY=00, EXOKAY=01, SLVERR=10, DECERR=11.
REQ-030 Timeout counter SHALL be sub-module axi_wait_timer (clear, enable, expired output).
REQ-031 Target RTL size 150-300 lines, no tristate outputs.

Verification
REQ-032 Write 0x0000_0010 <- 0xDEADBEEF strb 0xF, zero-wait slave -> rsp_valid at accept+3, resp 00, rsp_write 1.
REQ-033 Write with awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 4 cycles stable, single response.
REQ-034 Read 0x0000_0020, slave returns 0x12345678 rresp 00 after 2 wait cycles -> rsp_rdata 0x12345678, resp 00.
REQ-035 Read to 0x0002_0000, slave returns rresp 11 -> rsp_resp 11 passed through.
REQ-036 TIMEOUT=8, slave never asserts bvalid -> bready drops at 8th wait cycle, rsp_resp 10, next command accepted.
REQ-037 rsp_ready_i held 0 for 5 cycles, then rst_ni pulsed during a following read -> outputs reset, no response, cmd_ready_o 1.
